// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file, registered reads, optional
// zero register and write bypass, and a post-reset clear walk.
// Ports: i_clk, i_rst (sync, active-high); i_reg_addr_r/o_reg_r packed
// per-port read address/data; i_reg_addr_w, i_reg_val_w, i_write_en
// write port; o_ready (clear done); o_wr_err (write dropped in clear).
module reg_file_mp #(
  parameter int REG_WIDTH       = 32,
  parameter int REG_ADDR_LENGTH = 5,
  parameter int NUM_READ_PORTS  = 2,
  parameter int ZERO_REG_EN     = 1,
  parameter int BYPASS_EN       = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_READ_PORTS*REG_ADDR_LENGTH-1:0] i_reg_addr_r,
  output logic [NUM_READ_PORTS*REG_WIDTH-1:0]   o_reg_r,
  input  logic [REG_ADDR_LENGTH-1:0]            i_reg_addr_w,
  input  logic [REG_WIDTH-1:0]                  i_reg_val_w,
  input  logic                                  i_write_en,
  output logic                                  o_ready,
  output logic                                  o_wr_err
);

  localparam int DEPTH = 2 ** REG_ADDR_LENGTH;
  localparam logic [REG_ADDR_LENGTH-1:0] LAST = '1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [REG_ADDR_LENGTH-1:0] clr_cnt;
  logic [REG_WIDTH-1:0]       mem [DEPTH];

  logic                       mem_we;
  logic [REG_ADDR_LENGTH-1:0] mem_wa;
  logic [REG_WIDTH-1:0]       mem_wd;
  logic                       err_nxt;

  logic [NUM_READ_PORTS*REG_WIDTH-1:0] rd_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter parks on the last entry so it never starts a second pass.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clr_cnt <= '0;
    end else if (state == CLEAR && clr_cnt != LAST) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_wa    = i_reg_addr_w;
    mem_wd    = i_reg_val_w;
    err_nxt   = 1'b0;
    case (state)
      CLEAR: begin
        mem_we  = 1'b1;
        mem_wa  = clr_cnt;
        mem_wd  = '0;
        err_nxt = i_write_en;
        if (clr_cnt == LAST) begin
          state_nxt = READY;
        end
      end
      READY: begin
        mem_we = i_write_en &&
                 !((ZERO_REG_EN != 0) && i_reg_addr_w == '0);
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [REG_ADDR_LENGTH-1:0] ra;
    logic [REG_WIDTH-1:0]       rd;

    assign ra = i_reg_addr_r[p*REG_ADDR_LENGTH +: REG_ADDR_LENGTH];

    // Zero register outranks bypass; mem read is pre-write (old) data.
    always_comb begin
      rd = mem[ra];
      if ((BYPASS_EN != 0) && i_write_en && ra == i_reg_addr_w) begin
        rd = i_reg_val_w;
      end
      if ((ZERO_REG_EN != 0) && ra == '0) begin
        rd = '0;
      end
    end

    assign rd_nxt[p*REG_WIDTH +: REG_WIDTH] = rd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_reg_r  <= '0;
      o_ready  <= 1'b0;
      o_wr_err <= 1'b0;
    end else begin
      o_reg_r  <= (state == READY) ? rd_nxt : '0;
      o_ready  <= (state_nxt == READY);
      o_wr_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp, two configurations
// (32x32 2-port zero+bypass, 8x32 4-port plain) on one stimulus stream.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         we;
  logic [4:0]   wa;
  logic [31:0]  wv;
  logic [9:0]   ra_a;
  logic [11:0]  ra_b;
  logic [2:0]   wa_b;
  logic [63:0]  rd_a;
  logic [127:0] rd_b;
  logic         rdy_a;
  logic         err_a;
  logic         rdy_b;
  logic         err_b;

  assign wa_b = wa[2:0];

  reg_file_mp dut_a (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_reg_addr_r (ra_a),
    .o_reg_r      (rd_a),
    .i_reg_addr_w (wa),
    .i_reg_val_w  (wv),
    .i_write_en   (we),
    .o_ready      (rdy_a),
    .o_wr_err     (err_a)
  );

  reg_file_mp #(
    .REG_WIDTH       (32),
    .REG_ADDR_LENGTH (3),
    .NUM_READ_PORTS  (4),
    .ZERO_REG_EN     (0),
    .BYPASS_EN       (0)
  ) dut_b (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_reg_addr_r (ra_b),
    .o_reg_r      (rd_b),
    .i_reg_addr_w (wa_b),
    .i_reg_val_w  (wv),
    .i_write_en   (we),
    .o_ready      (rdy_b),
    .o_wr_err     (err_b)
  );

  typedef struct {
    logic [63:0]  rd_a;
    logic [127:0] rd_b;
    logic         rdy_a;
    logic         err_a;
    logic         rdy_b;
    logic         err_b;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [8];
  int rel_a = 0;
  int rel_b = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rd_a", {64'h0, rd_a}, {64'h0, e.rd_a});
      chk("rdy_a", {127'h0, rdy_a}, {127'h0, e.rdy_a});
      chk("err_a", {127'h0, err_a}, {127'h0, e.err_a});
      chk("rd_b", rd_b, e.rd_b);
      chk("rdy_b", {127'h0, rdy_b}, {127'h0, e.rdy_b});
      chk("err_b", {127'h0, err_b}, {127'h0, e.err_b});
    end
  end

  // Reference: a block is ready DEPTH non-reset edges after the last
  // reset edge; at that moment every entry is zero.
  task automatic cyc(input logic r, input logic w, input logic [4:0] a,
                     input logic [31:0] v, input logic [9:0] pa,
                     input logic [11:0] pb);
    exp_t e;
    logic [4:0] ad;
    logic [2:0] bd;
    @(negedge clk);
    #1;
    rst  = r;
    we   = w;
    wa   = a;
    wv   = v;
    ra_a = pa;
    ra_b = pb;
    e.rd_a  = '0;
    e.rd_b  = '0;
    e.err_a = 1'b0;
    e.err_b = 1'b0;
    if (r) begin
      rel_a   = 0;
      e.rdy_a = 1'b0;
    end else if (rel_a < 32) begin
      e.err_a = w;
      rel_a++;
      if (rel_a == 32) foreach (ma[i]) ma[i] = '0;
      e.rdy_a = (rel_a == 32);
    end else begin
      for (int p = 0; p < 2; p++) begin
        ad = pa[p*5 +: 5];
        if (ad == 0) e.rd_a[p*32 +: 32] = '0;
        else if (w && ad == a) e.rd_a[p*32 +: 32] = v;
        else e.rd_a[p*32 +: 32] = ma[ad];
      end
      if (w && a != 0) ma[a] = v;
      e.rdy_a = 1'b1;
    end
    if (r) begin
      rel_b   = 0;
      e.rdy_b = 1'b0;
    end else if (rel_b < 8) begin
      e.err_b = w;
      rel_b++;
      if (rel_b == 8) foreach (mb[i]) mb[i] = '0;
      e.rdy_b = (rel_b == 8);
    end else begin
      for (int p = 0; p < 4; p++) begin
        bd = pb[p*3 +: 3];
        e.rd_b[p*32 +: 32] = mb[bd];
      end
      if (w) mb[a[2:0]] = v;
      e.rdy_b = 1'b1;
    end
    sb.push_back(e);
  endtask

  function automatic logic [9:0] rnd_pa(input logic [4:0] a);
    logic [9:0] pa;
    for (int p = 0; p < 2; p++) begin
      if ($urandom_range(0, 2) == 0) pa[p*5 +: 5] = a;
      else pa[p*5 +: 5] = 5'($urandom);
    end
    return pa;
  endfunction

  function automatic logic [11:0] rnd_pb(input logic [4:0] a);
    logic [11:0] pb;
    for (int p = 0; p < 4; p++) begin
      if ($urandom_range(0, 2) == 0) pb[p*3 +: 3] = a[2:0];
      else pb[p*3 +: 3] = 3'($urandom);
    end
    return pb;
  endfunction

  initial begin
    logic [4:0]  a;
    logic [31:0] v;
    rst  = 1'b1;
    we   = 1'b0;
    wa   = '0;
    wv   = '0;
    ra_a = '0;
    ra_b = '0;
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;

    cyc(1, 0, 0, 0, 10'h3ff, 12'hfff);
    cyc(1, 1, 5, 32'hff, 10'h3ff, 12'hfff);
    for (int i = 0; i < 34; i++) begin
      if (i == 3) cyc(0, 1, 5, 32'hff, {5'd5, 5'd5}, 12'hb6d);
      else cyc(0, 0, 0, 0, 10'($urandom), 12'($urandom));
    end
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 0, 0, {5'(2*i+1), 5'(2*i)}, {3'(i), 3'(i+1), 3'(i+2), 3'(i+3)});

    cyc(0, 1, 7, 32'hdeadbeef, 0, 0);
    cyc(0, 0, 0, 0, {5'd7, 5'd7}, {4{3'd7}});
    cyc(0, 1, 0, 32'h12345678, {5'd0, 5'd0}, {4{3'd0}});
    cyc(0, 0, 0, 0, {5'd0, 5'd0}, {4{3'd0}});
    cyc(0, 1, 3, 32'ha5a5a5a5, {5'd3, 5'd1}, {3'd3, 3'd0, 3'd3, 3'd1});
    cyc(0, 0, 0, 0, {5'd3, 5'd3}, {4{3'd3}});

    for (int i = 0; i < 400; i++) begin
      a = 5'($urandom);
      v = $urandom;
      cyc(($urandom_range(0, 99) == 0), 1'($urandom), a, v,
          rnd_pa(a), rnd_pb(a));
    end
    for (int i = 0; i < 34; i++) cyc(0, 0, 0, 0, 0, 0);

    for (int i = 1; i < 32; i++)
      cyc(0, 1, 5'(i), {8'(i), 8'(i), 8'(i), 8'(i)} | 32'h1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 1'(i % 2), 5'(i), 32'hffff0000, {5'(i), 5'(i)}, 12'($urandom));
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++)
      cyc(0, (i == 4), 5, 32'hff, {5'(i), 5'(31-i)}, 12'($urandom));
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 0, 0, {5'(2*i+1), 5'(2*i)}, {3'(i), 3'(i+4), 3'(i+2), 3'(i+6)});

    repeat (3) @(negedge clk);
    #1;
    chk("drain", 128'(sb.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with registered reads, optional hardwired zero register, write-to-read bypass and a post-reset clear sequencer. It is the next generation of the team's 2-read/1-write register file: the datapath operand fetch stage reads all ports each cycle, and writeback drives the single write port. After reset the block walks every entry to zero and signals readiness before it accepts writes.

## Interface
Parameters:
- `REG_WIDTH`, 32: data width of each entry.
- `REG_ADDR_LENGTH`, 5: address width; depth `DEPTH = 2**REG_ADDR_LENGTH`.
- `NUM_READ_PORTS`, 2: number of independent read ports, 1..8.
- `ZERO_REG_EN`, 1: 1 = entry 0 always reads 0 and ignores writes.
- `BYPASS_EN`, 1: 1 = same-cycle write data is forwarded to a matching read.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_reg_addr_r`  in  `NUM_READ_PORTS*REG_ADDR_LENGTH`  packed read addresses; port p at bits `[p*REG_ADDR_LENGTH +: REG_ADDR_LENGTH]`.
- `o_reg_r`  out  `NUM_READ_PORTS*REG_WIDTH`  packed registered read data; port p at `[p*REG_WIDTH +: REG_WIDTH]`.
- `i_reg_addr_w`  in  `REG_ADDR_LENGTH`  write address.
- `i_reg_val_w`  in  `REG_WIDTH`  write data.
- `i_write_en`  in  1  write strobe.
- `o_ready`  out  1  1 = clear complete, writes accepted.
- `o_wr_err`  out  1  one-cycle pulse: a write was dropped because the block was not ready.

## Operation
- Two-state FSM: CLEAR, READY. Internal clear counter `clr_cnt`, `REG_ADDR_LENGTH` bits.
- `i_rst` = 1 at an edge: state <= CLEAR, `clr_cnt` <= 0, all `o_reg_r` <= 0, `o_ready` <= 0, `o_wr_err` <= 0. Memory contents are not touched by reset itself.
- CLEAR, `i_rst` = 0: each edge writes `mem[clr_cnt]` <= 0 and increments `clr_cnt`. On the edge that clears entry `DEPTH-1`, state <= READY. `clr_cnt` does not wrap into a second pass.
- CLEAR: `i_write_en` is ignored; `o_wr_err` <= `i_write_en`. All `o_reg_r` <= 0 regardless of address.
- READY: `i_write_en` = 1 writes `mem[i_reg_addr_w]` <= `i_reg_val_w`, except that when `ZERO_REG_EN` = 1 and the address is 0, the write is discarded silently and `o_wr_err` stays 0. `o_wr_err` <= 0.
- READY read, per port p, independent: registered value is
  - 0 if `ZERO_REG_EN` and addr_p = 0;
  - else `i_reg_val_w` if `BYPASS_EN`, `i_write_en` and addr_p = `i_reg_addr_w`;
  - else `mem[addr_p]` before this edge's write.
- With `BYPASS_EN` = 0, a same-cycle read of the written address returns the old value.
- Multiple ports may read the same address in the same cycle; all return identical data.
- `o_ready` is registered: 1 exactly when state = READY.

## Timing
- Read latency: 1 cycle. Address presented before edge k; data valid after edge k, held until next edge.
- Write latency: a write at edge k is visible to non-bypassed reads sampled at edge k+1.
- Clear duration: reset released (i_rst = 0 at edge r+1) -> entries 0..DEPTH-1 cleared on edges r+1..r+DEPTH -> `o_ready` = 1 after edge r+DEPTH.
- Reset mid-clear or in READY: restarts the full clear from entry 0 at the next edge with `i_rst` = 0.
- `o_wr_err` is asserted for exactly the cycle after each dropped write. It is never asserted in READY.
- No combinational path from any input to any output.

## Test plan
- Reset for 2 cycles, default params -> `o_ready` = 0 for 32 edges after release, then 1; all reads return 0; `o_reg_r` = 0 throughout reset.
- READY: write 0xDEADBEEF to addr 7, next cycle read addr 7 on port 0 and port 1 -> both ports show 0xDEADBEEF one cycle later.
- Write 0x12345678 to addr 0 while reading addr 0 -> read is 0, `o_wr_err` = 0; a later read of addr 0 is 0. With `ZERO_REG_EN` = 0, the same sequence reads back 0x12345678.
- Same-cycle write 0xA5A5A5A5 to addr 3 with port 1 reading addr 3 -> `BYPASS_EN` = 1: port 1 shows 0xA5A5A5A5 next cycle; `BYPASS_EN` = 0: port 1 shows the old value, and a read one cycle later shows 0xA5A5A5A5.
- During CLEAR, assert `i_write_en` to addr 5 with value 0xFF -> `o_wr_err` pulses 1 for one cycle; after ready, addr 5 reads 0.
- Fill entries 1..31 with nonzero data, assert `i_rst` for 1 cycle mid-run, then assert it again 10 cycles into CLEAR -> `o_ready` rises exactly 32 edges after the last release, and every entry reads 0. Repeat with `NUM_READ_PORTS` = 4 and `REG_ADDR_LENGTH` = 3: ready after 8 edges.
